// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types for the data-memory responder
// Purpose: FSM state encoding, latched-op encoding and latency counter width.
// Ports: none (package).
package dmem_pkg;

  // Latency counter width; it bounds LAT to 1..7.
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } dmem_op_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - memory-op handshake between stall unit and responder
// Purpose: groups the MEM-stage request and the responder's status/data.
// Ports (signals):
//   memRead, memWrite   request from MEM stage (held high while stalled)
//   address, writeData  byte address and store data
//   readData            registered load data
//   memBusy, memDone    access-in-progress flag and one-cycle completion pulse
// Modports: master = stall-unit / MEM-stage side, slave = responder side.
interface dmem_responder_if #(
  parameter int N = 64
);
  logic         memRead;
  logic         memWrite;
  logic [N-1:0] address;
  logic [N-1:0] writeData;
  logic [N-1:0] readData;
  logic         memBusy;
  logic         memDone;

  modport master (
    output memRead, memWrite, address, writeData,
    input  readData, memBusy, memDone
  );

  modport slave (
    input  memRead, memWrite, address, writeData,
    output readData, memBusy, memDone
  );
endinterface

// File: rtl/dmem_responder_lat_counter.sv
// rtl/dmem_responder_lat_counter.sv - loadable down-counter for access latency
// Purpose: counts the wait cycles of one memory access.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         load load_value this edge (takes priority over enable)
//   load_value   value loaded on load
//   enable       decrement this edge (saturates at zero)
//   expire       count is 1: the current enabled edge is the last one
module lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         expire
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == W'(1));
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - slow SRAM model answering the CPU memory-op handshake
// Purpose: accepts one load/store, waits LAT cycles holding memBusy, then
//   pulses memDone with registered read data.
// Parameters: N data/address width, DEPTH words (power of two), LAT 1..7.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    dmem_responder_if slave modport (request in, status/data out)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int N     = 64,
  parameter int DEPTH = 64,
  parameter int LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);

  if ((LAT < 1) || (LAT > 7)) begin : g_bad_lat
    $error("dmem_responder: LAT must be in 1..7");
  end
  if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two");
  end

  dmem_state_t state;
  dmem_state_t state_next;

  logic             req;
  logic             accept;
  logic             ctr_en;
  logic             expire;
  logic             busy;
  logic             done;

  dmem_op_t         req_op;
  logic [IDX_W-1:0] req_idx;
  logic [N-1:0]     req_wdata;
  logic [N-1:0]     read_q;

  logic [N-1:0]     mem [DEPTH];

  // Byte-address bits outside the word index are don't-care.
  logic addr_unused;
  assign addr_unused = ^{bus.address[N-1:IDX_W+3], bus.address[2:0]};

  assign req = bus.memRead | bus.memWrite;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (expire) state_next = DONE;
      DONE:    state_next = IDLE;  // requests ignored: completing op still presented
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output / control logic ----------------
  always_comb begin
    accept = 1'b0;
    ctr_en = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        // Busy already in the request cycle so the PC never advances past it.
        accept = req;
        busy   = req;
      end
      BUSY: begin
        ctr_en = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  lat_counter #(
    .W (LAT_W)
  ) u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (LAT_W'(LAT)),
    .enable     (ctr_en),
    .expire     (expire)
  );

  // Request latch: inputs may change while BUSY, only these copies are used.
  // A simultaneous read+write is treated as a store.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_op    <= OP_LOAD;
      req_idx   <= '0;
      req_wdata <= '0;
    end else if (accept) begin
      req_op    <= bus.memWrite ? OP_STORE : OP_LOAD;
      req_idx   <= bus.address[IDX_W+2:3];
      req_wdata <= bus.writeData;
    end
  end

  // Load data is captured on the completing edge and held until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_q <= '0;
    end else if ((state == BUSY) && expire && (req_op == OP_LOAD)) begin
      read_q <= mem[req_idx];
    end
  end

  // Array is not reset; a store pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && (state == BUSY) && expire && (req_op == OP_STORE)) begin
      mem[req_idx] <= req_wdata;
    end
  end

  assign bus.readData = read_q;
  assign bus.memBusy  = busy;
  assign bus.memDone  = done;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder (LAT=2 and LAT=1)
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if #(.N(64)) bus2 ();
  dmem_responder_if #(.N(64)) bus1 ();

  dmem_responder #(.N(64), .DEPTH(64), .LAT(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dmem_responder #(.N(64), .DEPTH(64), .LAT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          lat1     = 1'b0;
  logic [63:0] last_rd [2];
  logic [63:0] mdl [2][64];
  logic [63:0] exp_q [$];

  logic        busy_m;
  logic        done_m;
  logic [63:0] rd_m;
  assign busy_m = lat1 ? bus1.memBusy  : bus2.memBusy;
  assign done_m = lat1 ? bus1.memDone  : bus2.memDone;
  assign rd_m   = lat1 ? bus1.readData : bus2.readData;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
    if (lat1) begin
      bus1.memRead = r; bus1.memWrite = w; bus1.address = a; bus1.writeData = d;
    end else begin
      bus2.memRead = r; bus2.memWrite = w; bus2.address = a; bus2.writeData = d;
    end
  endtask

  // Called just after a rising edge; returns just after the edge following DONE.
  task automatic do_op(input string tag, input bit r, input bit w,
                       input logic [63:0] a, input logic [63:0] d, input bit hold);
    int lat;
    int li;
    int idx;
    lat = lat1 ? 1 : 2;
    li  = lat1 ? 1 : 0;
    idx = int'(a[8:3]);
    drive(r, w, a, d);
    if (w) mdl[li][idx] = d;
    else   exp_q.push_back(mdl[li][idx]);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk({tag, " busy"}, 64'(busy_m), 64'd1);
      chk({tag, " no done"}, 64'(done_m), 64'd0);
      @(posedge clk); #1;
      // Scramble the address/data while BUSY: only latched values may matter.
      if (c < lat) drive(r, w, 64'($urandom), {$urandom, $urandom});
    end
    if (!hold) drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk({tag, " done"}, 64'(done_m), 64'd1);
    chk({tag, " done busy"}, 64'(busy_m), 64'd0);
    if (!w) last_rd[li] = exp_q.pop_front();
    chk({tag, " readData"}, rd_m, last_rd[li]);
    @(posedge clk); #1;
  endtask

  initial begin
    last_rd[0] = 64'd0;
    last_rd[1] = 64'd0;
    reset = 1'b1;
    lat1 = 1'b1; drive(1'b0, 1'b0, 64'd0, 64'd0);
    lat1 = 1'b0; drive(1'b0, 1'b0, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy2", 64'(bus2.memBusy), 64'd0);
    chk("rst done2", 64'(bus2.memDone), 64'd0);
    chk("rst rd2", bus2.readData, 64'd0);
    chk("rst busy1", 64'(bus1.memBusy), 64'd0);
    chk("rst done1", 64'(bus1.memDone), 64'd0);
    chk("rst rd1", bus1.readData, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the first BUSY cycle drops the pending store.
    do_op("pre store 0x20", 1'b0, 1'b1, 64'h20, 64'h1234, 1'b0);
    drive(1'b0, 1'b1, 64'h20, 64'hDEAD);
    @(negedge clk);
    chk("midrst req busy", 64'(busy_m), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk("midrst busy1", 64'(busy_m), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst busy", 64'(busy_m), 64'd0);
    chk("midrst done", 64'(done_m), 64'd0);
    chk("midrst rd", rd_m, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst no late done", 64'(done_m), 64'd0);
    @(posedge clk); #1;
    do_op("load 0x20 after rst", 1'b1, 1'b0, 64'h20, 64'd0, 1'b0);

    // Store then back-to-back load.
    do_op("store 0x10", 1'b0, 1'b1, 64'h10, 64'h1122334455667788, 1'b0);
    do_op("load 0x10", 1'b1, 1'b0, 64'h10, 64'd0, 1'b0);

    // Held request: one done, then re-accepted in the next IDLE cycle.
    do_op("held load 1", 1'b1, 1'b0, 64'h10, 64'd0, 1'b1);
    do_op("held load 2", 1'b1, 1'b0, 64'h10, 64'd0, 1'b0);

    // Simultaneous read+write acts as a store; readData unchanged.
    do_op("rw store 0x8", 1'b1, 1'b1, 64'h8, 64'hAA, 1'b0);
    do_op("load 0x8", 1'b1, 1'b0, 64'h8, 64'd0, 1'b0);

    // Address wrap: 0x208 aliases word 1.
    do_op("store 0x208", 1'b0, 1'b1, 64'h208, 64'h55, 1'b0);
    do_op("load 0x008", 1'b1, 1'b0, 64'h008, 64'd0, 1'b0);

    // LAT=1 build.
    lat1 = 1'b1;
    do_op("l1 store 0x18", 1'b0, 1'b1, 64'h18, 64'hA5A5_0000_1111_2222, 1'b0);
    do_op("l1 store 0x28", 1'b0, 1'b1, 64'h28, 64'h0F0F_3333_4444_5555, 1'b0);
    do_op("l1 load 0x18", 1'b1, 1'b0, 64'h18, 64'd0, 1'b0);
    do_op("l1 load 0x28", 1'b1, 1'b0, 64'h28, 64'd0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
